// File: rtl/channel_row_tracker.sv
// channel_row_tracker: latches channel enables per frame, divides the free rows among visible channels, and tracks which channel owns each raster row.
//   Ports: clk, rst_n (async active-low); channel_enable, frame_start, line_start in;
//   cfg_ready, is_channel, channel_number, channel_row, channel_first, channel_last, late out.
module channel_row_tracker #(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int VER_RES = 480,
  parameter int OFFSET = 0,
  parameter int GAP = 0,
  localparam int ROW_W = $clog2(VER_RES),
  localparam int CH_W = ($clog2(MAX_CHAN_COUNT) > 0) ? $clog2(MAX_CHAN_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic                      frame_start,
  input  logic                      line_start,
  output logic                      cfg_ready,
  output logic                      is_channel,
  output logic [CH_W-1:0]           channel_number,
  output logic [ROW_W-1:0]          channel_row,
  output logic                      channel_first,
  output logic                      channel_last,
  output logic                      late
);
  localparam int DC_W = $clog2(ROW_W + 1);
  localparam logic [DC_W-1:0] D_LAST = DC_W'(ROW_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(VER_RES - 1);
  localparam logic [ROW_W-1:0] OFF_LAST = ROW_W'(OFFSET > 0 ? OFFSET - 1 : 0);
  localparam logic [ROW_W-1:0] GAP_LAST = ROW_W'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {IDLE, CALC, DIVIDE, READY} state_t;
  typedef enum logic [1:0] {P_OFF, P_CHAN, P_GAP, P_DONE} phase_t;
  state_t state, nstate;
  phase_t phase;
  logic [MAX_CHAN_COUNT-1:0] shadow;
  logic [CH_W:0] pop, divisor, rem, first_ch, nxt;
  logic [CH_W+1:0] trial;
  logic [31:0] gap_total;
  logic skip, take;
  logic [ROW_W-1:0] avail, q, row, cnt;
  logic [DC_W-1:0] dcnt;
  logic [CH_W-1:0] ch;
  // Returns {found, index} of the lowest enabled bit at or above 'from'.
  function automatic logic [CH_W:0] find_next(input logic [MAX_CHAN_COUNT-1:0] en, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = MAX_CHAN_COUNT - 1; i >= 0; i--)
      if (en[i] && i >= from) r = {1'b1, CH_W'(i)};
    return r;
  endfunction
  always_comb begin
    pop = '0;
    for (int i = 0; i < MAX_CHAN_COUNT; i++) pop = pop + (CH_W + 1)'(shadow[i]);
    gap_total = (pop == '0) ? '0 : 32'(GAP) * (32'(pop) - 32'd1);
    skip = (pop == '0) || (gap_total >= 32'(VER_RES - OFFSET));
    avail = ROW_W'(32'(VER_RES - OFFSET) - gap_total);
    trial = {rem, q[ROW_W-1]};
    take = trial >= {1'b0, divisor};
    first_ch = find_next(channel_enable, 0);
    nxt = find_next(shadow, int'(ch) + 1);
    nstate = frame_start ? CALC :
             state == CALC ? (skip ? READY : DIVIDE) :
             (state == DIVIDE && dcnt == D_LAST) ? READY : state;
  end
  assign cfg_ready = state == READY;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  // Restoring divider: q starts as the dividend and ends as the quotient, which is the channel height.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      q <= '0;
      divisor <= '0;
      dcnt <= '0;
    end else if (state == CALC) begin
      rem <= '0;
      q <= skip ? '0 : avail;
      divisor <= pop;
      dcnt <= '0;
    end else if (state == DIVIDE) begin
      rem <= take ? (CH_W + 1)'(trial - {1'b0, divisor}) : (CH_W + 1)'(trial);
      q <= {q[ROW_W-2:0], take};
      dcnt <= dcnt + 1'b1;
    end
  // The phase/ch/cnt registers describe the row the next line_start will present.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= '0;
      phase <= P_DONE;
      ch <= '0;
      cnt <= '0;
      row <= '0;
      late <= 1'b0;
      is_channel <= 1'b0;
      channel_number <= '0;
      channel_row <= '0;
      channel_first <= 1'b0;
      channel_last <= 1'b0;
    end else if (frame_start) begin
      shadow <= channel_enable;
      phase <= OFFSET > 0 ? P_OFF : P_CHAN;
      ch <= first_ch[CH_W-1:0];
      cnt <= '0;
      row <= '0;
      late <= 1'b0;
      is_channel <= 1'b0;
      channel_number <= '0;
      channel_row <= '0;
      channel_first <= 1'b0;
      channel_last <= 1'b0;
    end else if (line_start) begin
      row <= row == ROW_MAX ? row : row + 1'b1;
      is_channel <= 1'b0;
      channel_number <= '0;
      channel_row <= '0;
      channel_first <= 1'b0;
      channel_last <= 1'b0;
      if (state != READY) begin
        late <= 1'b1;
        phase <= P_DONE;
      end else begin
        case (phase)
          P_OFF: if (row == OFF_LAST) phase <= P_CHAN;
          P_CHAN:
            if (q == '0) phase <= P_DONE;
            else begin
              is_channel <= 1'b1;
              channel_number <= ch;
              channel_row <= cnt;
              channel_first <= cnt == '0;
              channel_last <= cnt == q - 1'b1;
              if (cnt == q - 1'b1) begin
                cnt <= '0;
                ch <= nxt[CH_W-1:0];
                phase <= !nxt[CH_W] ? P_DONE : GAP > 0 ? P_GAP : P_CHAN;
              end else cnt <= cnt + 1'b1;
            end
          P_GAP:
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              phase <= P_CHAN;
            end else cnt <= cnt + 1'b1;
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_channel_row_tracker.sv
// tb_channel_row_tracker: checks two tracker instances (plain, and offset/gap) against vectors and an arithmetic row-ownership model.
module tb_channel_row_tracker;
  localparam int VER = 480;
  localparam int RW = 9;
  logic clk = 0, rst_n = 0, frame_start = 0, line_start = 0;
  logic [9:0] channel_enable = '0;
  logic rdy0, is0, f0, l0, late0, rdy1, is1, f1, l1, late1;
  logic [3:0] ch0, ch1;
  logic [8:0] row0, row1;
  logic [15:0] out0, out1;
  int checks = 0, failures = 0, cur_r = 0;
  logic [9:0] cur_en = '0;
  always #5 clk = ~clk;
  channel_row_tracker u0 (.clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .frame_start(frame_start),
    .line_start(line_start), .cfg_ready(rdy0), .is_channel(is0), .channel_number(ch0), .channel_row(row0),
    .channel_first(f0), .channel_last(l0), .late(late0));
  channel_row_tracker #(.OFFSET(20), .GAP(4)) u1 (.clk(clk), .rst_n(rst_n), .channel_enable(channel_enable),
    .frame_start(frame_start), .line_start(line_start), .cfg_ready(rdy1), .is_channel(is1), .channel_number(ch1),
    .channel_row(row1), .channel_first(f1), .channel_last(l1), .late(late1));
  assign out0 = {is0, ch0, row0, f0, l0};
  assign out1 = {is1, ch1, row1, f1, l1};
  function automatic logic [15:0] pk(input bit i, input int c, input int rw, input bit f, input bit l);
    return {i, 4'(c), 9'(rw), f, l};
  endfunction
  // Row ownership from the frame layout: offset, then equal slots of (height + gap) per visible channel.
  function automatic logic [15:0] model(input logic [9:0] en, input int off, input int gap, input int r);
    int n, h, k, idx, w, seen;
    n = $countones(en);
    h = (n == 0 || gap * (n - 1) >= VER - off) ? 0 : (VER - off - gap * (n - 1)) / n;
    if (h == 0 || r < off || r >= VER) return '0;
    k = r - off;
    idx = k / (h + gap);
    w = k % (h + gap);
    if (idx >= n || w >= h) return '0;
    seen = 0;
    for (int j = 0; j < 10; j++)
      if (en[j]) begin
        if (seen == idx) return pk(1, j, w, w == 0, w == h - 1);
        seen++;
      end
    return '0;
  endfunction
  task automatic chk(input string name, input int r, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, r, got, exp);
    end
  endtask
  task automatic start_frame(input logic [9:0] en, input bit with_line);
    @(negedge clk);
    channel_enable = en;
    frame_start = 1;
    line_start = with_line;
    @(negedge clk);
    frame_start = 0;
    line_start = 0;
    channel_enable = 10'($urandom);
    cur_en = en;
    cur_r = 0;
    repeat (12) @(negedge clk);
  endtask
  task automatic pulse_line();
    @(negedge clk);
    line_start = 1;
    @(negedge clk);
    line_start = 0;
  endtask
  task automatic line_and_check();
    pulse_line();
    chk("u0_row", cur_r, 32'(out0), 32'(model(cur_en, 0, 0, cur_r)));
    chk("u1_row", cur_r, 32'(out1), 32'(model(cur_en, 20, 4, cur_r)));
    cur_r++;
  endtask
  typedef struct {int dut; logic [9:0] en; int r; logic [15:0] exp;} vec_t;
  vec_t vecs[16];
  initial begin
    vecs[0] = '{0, 10'h025, 0, pk(1, 0, 0, 1, 0)};
    vecs[1] = '{0, 10'h025, 159, pk(1, 0, 159, 0, 1)};
    vecs[2] = '{0, 10'h025, 160, pk(1, 2, 0, 1, 0)};
    vecs[3] = '{0, 10'h025, 319, pk(1, 2, 159, 0, 1)};
    vecs[4] = '{0, 10'h025, 320, pk(1, 5, 0, 1, 0)};
    vecs[5] = '{0, 10'h025, 479, pk(1, 5, 159, 0, 1)};
    vecs[6] = '{1, 10'h003, 19, '0};
    vecs[7] = '{1, 10'h003, 20, pk(1, 0, 0, 1, 0)};
    vecs[8] = '{1, 10'h003, 247, pk(1, 0, 227, 0, 1)};
    vecs[9] = '{1, 10'h003, 248, '0};
    vecs[10] = '{1, 10'h003, 251, '0};
    vecs[11] = '{1, 10'h003, 252, pk(1, 1, 0, 1, 0)};
    vecs[12] = '{1, 10'h003, 479, pk(1, 1, 227, 0, 1)};
    vecs[13] = '{0, 10'h07F, 475, pk(1, 6, 67, 0, 1)};
    vecs[14] = '{0, 10'h07F, 476, '0};
    vecs[15] = '{0, 10'h07F, 479, '0};
    repeat (3) @(negedge clk);
    chk("reset_out", 0, {out0, out1}, '0);
    chk("reset_flags", 0, 32'({rdy0, late0, rdy1, late1}), '0);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_out", 0, {out0, out1}, '0);
    // cfg_ready latency: skipped divide, then full divide
    @(negedge clk);
    channel_enable = '0;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    chk("rdy_skip_e0", 0, 32'(rdy0), 0);
    @(negedge clk);
    chk("rdy_skip_e1", 1, 32'(rdy0), 1);
    channel_enable = 10'h025;
    frame_start = 1;
    for (int k = 0; k <= RW + 1; k++) begin
      @(negedge clk);
      frame_start = 0;
      if (k == RW) chk("rdy_div_early", k, 32'({rdy0, rdy1}), 0);
      if (k == RW + 1) chk("rdy_div_on", k, 32'({rdy0, rdy1}), 3);
    end
    for (int v = 0; v < 16; v++) begin
      if (v == 0 || vecs[v].en != cur_en || vecs[v].r < cur_r) start_frame(vecs[v].en, 0);
      while (cur_r < vecs[v].r) line_and_check();
      pulse_line();
      chk($sformatf("vec%0d", v), vecs[v].r, 32'(vecs[v].dut == 0 ? out0 : out1), 32'(vecs[v].exp));
      cur_r++;
    end
    for (int f = 0; f < 10; f++) begin
      start_frame(f == 0 ? 10'h000 : f == 1 ? 10'h3FF : 10'($urandom), 0);
      for (int i = 0; i < VER + 2; i++) line_and_check();
    end
    // line_start before cfg_ready abandons the frame
    @(negedge clk);
    channel_enable = 10'h3FF;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    repeat (2) @(negedge clk);
    pulse_line();
    chk("late_set", 0, 32'({late0, late1, is0, is1}), 32'b1100);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_line();
      chk("late_abandon", i + 1, 32'({late0, late1, out0, out1}), {2'b11, 32'h0});
    end
    start_frame(10'h3FF, 0);
    chk("late_clear", 0, 32'({late0, late1}), 0);
    for (int i = 0; i < 5; i++) line_and_check();
    // frame_start beats a simultaneous line_start
    start_frame(10'h011, 1);
    chk("fs_wins", 0, {out0, out1}, '0);
    for (int i = 0; i < 40; i++) line_and_check();
    // async reset in the middle of the divide
    @(negedge clk);
    channel_enable = 10'h025;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_div", 0, {out0, out1}, '0);
    chk("rst_mid_rdy", 0, 32'({rdy0, rdy1, late0, late1}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (14) @(negedge clk);
    chk("idle_after_rst", 0, 32'({rdy0, rdy1}), 0);
    start_frame(10'h025, 0);
    for (int i = 0; i < VER; i++) line_and_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
